// File: rtl/tx_frame_controller.sv
// rtl/tx_frame_controller.sv - byte-frame sequencer for the serial TX timer and shift register
//
// Purpose:
//   Takes one byte at a time from the TX byte FIFO and builds a frame
//   {stop=1, data, start=0}. It parallel-loads the frame into the TX shift
//   register and runs the bit timer. It counts shift strobes to the end of
//   the frame, then holds the line idle for GAP_CYCLES clocks before it
//   accepts the next byte.
//
// Ports:
//   clk           - system clock, rising edge
//   rst           - synchronous active-high reset
//   tx_valid      - upstream byte available
//   tx_data       - byte to send, captured when tx_valid & tx_ready
//   tx_ready      - byte can be accepted (IDLE only, combinational)
//   abort         - cancel the frame in progress (ignored in IDLE)
//   shift_strobe  - timer pulse at the end of each bit period
//   clear_timer   - synchronous clear of the timer counters
//   disable_timer - 1 freezes the timer
//   load_enable   - one-cycle parallel load of load_data
//   load_data     - {1'b1, byte, 1'b0}; start bit (LSB) goes out first
//   busy          - controller is not IDLE
//   frame_done    - one-cycle pulse when a frame and its gap are complete
//   aborted       - one-cycle pulse when an abort is taken
//   frame_count   - completed frames, wraps modulo 2^CNT_W

module tx_frame_controller #(
  parameter int DATA_BITS  = 8,
  parameter int GAP_CYCLES = 28,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  input  logic                 abort,
  input  logic                 shift_strobe,
  output logic                 clear_timer,
  output logic                 disable_timer,
  output logic                 load_enable,
  output logic [DATA_BITS+1:0] load_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 aborted,
  output logic [CNT_W-1:0]     frame_count
);

  localparam int FB   = DATA_BITS + 2;
  localparam int BS_W = $clog2(FB + 1);
  localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BS_W-1:0] BS_LAST  = BS_W'(FB - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [BS_W-1:0]     bits_q, bits_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [FB-1:0]       load_data_q, load_data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                clear_q, clear_d;
  logic                disable_q, disable_d;
  logic                load_en_q, load_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;

  // Every output except tx_ready is registered. The next-state logic
  // computes each output value for the state being entered, so the
  // outputs line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    bits_d      = bits_q;
    gap_d       = gap_q;
    load_data_d = load_data_q;
    count_d     = count_q;
    clear_d     = 1'b0;
    disable_d   = 1'b1;
    load_en_d   = 1'b0;
    done_d      = 1'b0;
    aborted_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          load_data_d = {1'b1, tx_data, 1'b0};
          load_en_d   = 1'b1;
          clear_d     = 1'b1;
          bits_d      = '0;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        if (!abort) begin
          disable_d = 1'b0;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        if (!abort) begin
          disable_d = 1'b0;
          if (shift_strobe) begin
            if (bits_q == BS_LAST) begin
              // The last bit period is over. Stop and clear the timer
              // so that the line rests at the stop level.
              clear_d   = 1'b1;
              disable_d = 1'b1;
              if (GAP_CYCLES == 0) begin
                done_d  = 1'b1;
                count_d = count_q + CNT_W'(1);
                state_d = S_IDLE;
              end else begin
                gap_d   = '0;
                state_d = S_GAP;
              end
            end else begin
              bits_d = bits_q + BS_W'(1);
            end
          end
        end
      end

      S_GAP: begin
        if (!abort) begin
          if (gap_q == GAP_LAST) begin
            done_d  = 1'b1;
            count_d = count_q + CNT_W'(1);
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort takes priority over the final strobe and the end of the gap.
    // The frame is dropped and not counted, and the line goes back to idle.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      clear_d     = 1'b1;
      disable_d   = 1'b1;
      aborted_d   = 1'b1;
      done_d      = 1'b0;
      load_en_d   = 1'b0;
      count_d     = count_q;
      load_data_d = '1;
      bits_d      = '0;
      gap_d       = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bits_q      <= '0;
      gap_q       <= '0;
      load_data_q <= '1;
      count_q     <= '0;
      clear_q     <= 1'b0;
      disable_q   <= 1'b1;
      load_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_q      <= bits_d;
      gap_q       <= gap_d;
      load_data_q <= load_data_d;
      count_q     <= count_d;
      clear_q     <= clear_d;
      disable_q   <= disable_d;
      load_en_q   <= load_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign tx_ready      = (state_q == S_IDLE);
  assign clear_timer   = clear_q;
  assign disable_timer = disable_q;
  assign load_enable   = load_en_q;
  assign load_data     = load_data_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign aborted       = aborted_q;
  assign frame_count   = count_q;

endmodule

// File: tb/tb_tx_frame_controller.sv
// tb/tb_tx_frame_controller.sv - scoreboard bench for tx_frame_controller

module tb_tx_frame_controller;

  localparam int PER  = 28;   // main timer bit period
  localparam int GAP  = 28;
  localparam int PER0 = 3;    // bit period for the zero-gap instance

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // main instance: GAP_CYCLES=28, CNT_W=16
  logic       m_valid, m_abort, m_xstrobe, m_tstrobe;
  logic [7:0] m_data;
  logic       m_ready, m_clear, m_disable, m_load_en, m_busy, m_done, m_aborted;
  logic [9:0] m_load_data;
  logic [15:0] m_fc;

  // zero-gap instance: GAP_CYCLES=0, CNT_W=4 (used for the wrap check)
  logic       z_valid, z_abort, z_tstrobe;
  logic [7:0] z_data;
  logic       z_ready, z_clear, z_disable, z_load_en, z_busy, z_done, z_aborted;
  logic [9:0] z_load_data;
  logic [3:0] z_fc;

  tx_frame_controller #(.DATA_BITS(8), .GAP_CYCLES(GAP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .tx_valid(m_valid), .tx_data(m_data), .tx_ready(m_ready),
    .abort(m_abort), .shift_strobe(m_tstrobe | m_xstrobe), .clear_timer(m_clear),
    .disable_timer(m_disable), .load_enable(m_load_en), .load_data(m_load_data),
    .busy(m_busy), .frame_done(m_done), .aborted(m_aborted), .frame_count(m_fc)
  );

  tx_frame_controller #(.DATA_BITS(8), .GAP_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .tx_valid(z_valid), .tx_data(z_data), .tx_ready(z_ready),
    .abort(z_abort), .shift_strobe(z_tstrobe), .clear_timer(z_clear),
    .disable_timer(z_disable), .load_enable(z_load_en), .load_data(z_load_data),
    .busy(z_busy), .frame_done(z_done), .aborted(z_aborted), .frame_count(z_fc)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=pulse required=none", nm);
  endtask

  // scoreboard queues
  logic [9:0]  exp_ld[$];
  logic [15:0] exp_fc[$];
  logic [15:0] exp_ab[$];
  logic [3:0]  exp_zfc[$];

  // timer models: count while enabled, strobe at the end of each bit period
  int m_tcnt = 0, m_sn = 0, z_tcnt = 0, z_sn = 0;
  initial begin
    m_tstrobe = 1'b0;
    z_tstrobe = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m_load_en) m_sn = 0;
      if (m_clear || m_disable) begin
        m_tcnt = 0; m_tstrobe = 1'b0;
      end else begin
        m_tstrobe = (m_tcnt == PER - 1);
        m_tcnt    = m_tstrobe ? 0 : m_tcnt + 1;
        if (m_tstrobe) m_sn++;
      end
      if (z_load_en) z_sn = 0;
      if (z_clear || z_disable) begin
        z_tcnt = 0; z_tstrobe = 1'b0;
      end else begin
        z_tstrobe = (z_tcnt == PER0 - 1);
        z_tcnt    = z_tstrobe ? 0 : z_tcnt + 1;
        if (z_tstrobe) z_sn++;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents an output pulse
  int   m_since = 1000, z_since = 1000;
  logic m_le_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      m_since++;
      z_since++;
      if (m_load_en) begin
        if (exp_ld.size() == 0) unexpected("load_enable_unexpected");
        else check("load_data", 32'(m_load_data), 32'(exp_ld.pop_front()));
        check("load_enable_one_cycle", 32'(m_le_prev), 0);
      end
      if (m_done) begin
        check("done_and_aborted", 32'(m_aborted), 0);
        check("gap_length", 32'(m_since), 32'(GAP + 1));
        check("ready_at_done", 32'(m_ready), 1);
        if (exp_fc.size() == 0) unexpected("frame_done_unexpected");
        else check("frame_count_at_done", 32'(m_fc), 32'(exp_fc.pop_front()));
      end
      if (m_aborted) begin
        check("abort_clear_timer", 32'(m_clear), 1);
        if (exp_ab.size() == 0) unexpected("aborted_unexpected");
        else check("frame_count_at_abort", 32'(m_fc), 32'(exp_ab.pop_front()));
      end
      if (z_done) begin
        check("z_done_after_last_strobe", 32'(z_since), 1);
        check("z_ready_at_done", 32'(z_ready), 1);
        if (exp_zfc.size() == 0) unexpected("z_frame_done_unexpected");
        else check("z_frame_count", 32'(z_fc), 32'(exp_zfc.pop_front()));
      end
      if (z_aborted) unexpected("z_aborted_unexpected");
      if (m_tstrobe && m_sn == 10) m_since = 0;
      if (z_tstrobe && z_sn == 10) z_since = 0;
      m_le_prev = m_load_en;
    end
  end

  task automatic m_send(input logic [7:0] b, input bit hold);
    int n = 0;
    m_valid = 1'b1;
    m_data  = b;
    do begin @(posedge clk); #1; n++; end while (!m_load_en && n < 2000);
    if (!hold) m_valid = 1'b0;
    check("accept_seen", 32'(m_load_en), 1);
  endtask

  task automatic m_wait_idle();
    int n = 0;
    while (!m_ready && n < 2000) begin @(posedge clk); #1; n++; end
    check("back_to_idle", 32'(m_ready), 1);
  endtask

  task automatic m_wait_strobe(input int k);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(m_tstrobe && m_sn == k) && n < 2000);
    check("strobe_reached", 32'(m_tstrobe && m_sn == k), 1);
  endtask

  // hand-computed {1, byte, 0} frames
  logic [7:0] b3 [3] = '{8'h3C, 8'h81, 8'hFF};
  logic [9:0] f3 [3] = '{10'h278, 10'h302, 10'h3FE};

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_valid = 0; m_data = 0; m_abort = 0; m_xstrobe = 0;
    z_valid = 0; z_data = 0; z_abort = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // 1: reset state
    check("rst_disable_timer", 32'(m_disable), 1);
    check("rst_clear_timer", 32'(m_clear), 0);
    check("rst_busy", 32'(m_busy), 0);
    check("rst_tx_ready", 32'(m_ready), 1);
    check("rst_frame_count", 32'(m_fc), 0);
    check("rst_load_data", 32'(m_load_data), 32'h3FF);
    check("rst_load_enable", 32'(m_load_en), 0);
    rst = 1'b0;

    // strobe outside SEND is ignored
    @(posedge clk); #1; m_xstrobe = 1'b1;
    @(posedge clk); #1; m_xstrobe = 1'b0;
    check("idle_strobe_busy", 32'(m_busy), 0);
    check("idle_strobe_ready", 32'(m_ready), 1);

    // 2: single frame 8'hA5
    exp_ld.push_back(10'h34A);
    exp_fc.push_back(16'd1);
    m_send(8'hA5, 1'b0);
    check("load_busy", 32'(m_busy), 1);
    check("load_ready", 32'(m_ready), 0);
    check("load_clear_timer", 32'(m_clear), 1);
    check("load_disable_timer", 32'(m_disable), 1);
    @(posedge clk); #1;
    check("send_load_enable", 32'(m_load_en), 0);
    check("send_disable_timer", 32'(m_disable), 0);
    check("send_clear_timer", 32'(m_clear), 0);
    m_wait_idle();
    check("count_after_one", 32'(m_fc), 1);

    // 3: tx_valid held across three bytes
    for (int i = 0; i < 3; i++) begin
      exp_ld.push_back(f3[i]);
      exp_fc.push_back(16'(2 + i));
      m_send(b3[i], 1'b1);
    end
    m_valid = 1'b0;
    m_wait_idle();
    check("count_after_four", 32'(m_fc), 4);

    // abort in IDLE is ignored
    m_abort = 1'b1;
    @(posedge clk); #1; m_abort = 1'b0;
    check("idle_abort_ignored", 32'(m_aborted), 0);

    // 4: abort after the 4th strobe
    exp_ld.push_back(10'h2B4);
    exp_ab.push_back(16'd4);
    m_send(8'h5A, 1'b0);
    m_wait_strobe(4);
    @(posedge clk); #1; m_abort = 1'b1;
    @(posedge clk); #1; m_abort = 1'b0;
    check("abort4_aborted", 32'(m_aborted), 1);
    check("abort4_busy", 32'(m_busy), 0);
    check("abort4_ready", 32'(m_ready), 1);
    check("abort4_disable", 32'(m_disable), 1);
    check("abort4_line_idle", 32'(m_load_data), 32'h3FF);
    @(posedge clk); #1;
    check("abort4_pulse_end", 32'(m_aborted), 0);
    check("abort4_clear_end", 32'(m_clear), 0);

    // 5: abort together with the 10th strobe, then a normal frame
    exp_ld.push_back(10'h386);
    exp_ab.push_back(16'd4);
    m_send(8'hC3, 1'b0);
    m_wait_strobe(10);
    m_abort = 1'b1;
    @(posedge clk); #1; m_abort = 1'b0;
    check("abort10_aborted", 32'(m_aborted), 1);
    check("abort10_no_done", 32'(m_done), 0);
    check("abort10_count", 32'(m_fc), 4);
    exp_ld.push_back(10'h200);
    exp_fc.push_back(16'd5);
    m_send(8'h00, 1'b0);
    m_wait_idle();
    check("count_after_five", 32'(m_fc), 5);

    // 6: zero-gap build, 16 back-to-back frames, 4-bit counter wraps
    z_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int n = 0;
      z_data = 8'(i * 17);
      exp_zfc.push_back(4'(i + 1));
      do begin @(posedge clk); #1; n++; end while (!z_load_en && n < 2000);
      check("z_accept_seen", 32'(z_load_en), 1);
    end
    z_valid = 1'b0;
    begin
      int n = 0;
      while (!z_ready && n < 2000) begin @(posedge clk); #1; n++; end
    end
    @(posedge clk); #1;
    check("z_count_wrapped", 32'(z_fc), 0);

    repeat (2) @(posedge clk);
    #1;
    check("ld_queue_empty", 32'(exp_ld.size()), 0);
    check("fc_queue_empty", 32'(exp_fc.size()), 0);
    check("ab_queue_empty", 32'(exp_ab.size()), 0);
    check("zfc_queue_empty", 32'(exp_zfc.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
